// File: rtl/issue_unit.sv
// Single-issue sequencer: accepts one instruction, feeds a registered external ALU,
// and writes the ALU result back into a 4x8 register file (r0 hardwired to zero).
module issue_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_ans,
  output logic        wb_valid,
  output logic [1:0]  wb_addr,
  output logic [7:0]  wb_data,
  output logic        err,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'b101;

  state_t      state_q, state_d;
  logic [7:0]  rf_q [4];
  logic [7:0]  rf_d [4];
  logic [2:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [1:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic [1:0]  wb_addr_q, wb_addr_d;
  logic [7:0]  wb_data_q, wb_data_d;
  logic        err_q, err_d;

  logic [2:0]  in_op;
  logic        in_imm;
  logic [1:0]  in_rd, in_rs, in_rt;
  logic [7:0]  in_imm8;

  assign in_op   = instr[15:13];
  assign in_imm  = instr[12];
  assign in_rd   = instr[11:10];
  assign in_rs   = instr[9:8];
  assign in_imm8 = instr[7:0];
  assign in_rt   = instr[1:0];

  function automatic logic [7:0] read_reg(input logic [1:0] addr, input logic [7:0] rf [4]);
    return (addr == 2'd0) ? 8'h00 : rf[addr];
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    rf_d       = rf_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (in_op == OP_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            alu_op_d = in_op;
            alu_a_d  = read_reg(in_rs, rf_q);
            alu_b_d  = in_imm ? in_imm8 : read_reg(in_rt, rf_q);
            rd_d     = in_rd;
            state_d  = EXEC;
          end
        end
      end
      // The ALU samples alu_* on the EXEC->WB edge; alu_ans is valid during WB.
      EXEC: state_d = WB;
      WB: begin
        if (rd_q != 2'd0) rf_d[rd_q] = alu_ans;
        wb_valid_d = 1'b1;
        wb_addr_d  = rd_q;
        wb_data_d  = alu_ans;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the register file is cleared by reset like any other flop because
  // software-visible state must read 0 immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples its _d value from before the edge.
      state_q    <= IDLE;
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
      alu_op_q   <= 3'b000;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      rd_q       <= 2'd0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 2'd0;
      wb_data_q  <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign err         = err_q;
  assign dbg_data    = read_reg(dbg_addr, rf_q);

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: models the external registered ALU and scores writebacks
// against expected {addr,data} pairs queued when each instruction is offered.
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic [7:0]  alu_ans = 8'h00;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        err;
  logic [1:0]  dbg_addr = 2'd0;
  logic [7:0]  dbg_data;

  int total = 0;
  int bad = 0;
  logic [9:0] sb_q [$];
  logic [9:0] exp_wb;

  issue_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ans(alu_ans), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 110 SLT, 111 BZ (a==0).
  always @(posedge clk) begin
    case (alu_op)
      3'b000:  alu_ans <= alu_a + alu_b;
      3'b001:  alu_ans <= alu_a - alu_b;
      3'b010:  alu_ans <= alu_a & alu_b;
      3'b011:  alu_ans <= alu_a | alu_b;
      3'b100:  alu_ans <= alu_a ^ alu_b;
      3'b110:  alu_ans <= (alu_a < alu_b) ? 8'h01 : 8'h00;
      3'b111:  alu_ans <= (alu_a == 8'h00) ? 8'h01 : 8'h00;
      default: alu_ans <= 8'h00;
    endcase
  end

  // Writeback monitor: every wb_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got addr=%0d data=%h exp none", wb_addr, wb_data);
      end else begin
        exp_wb = sb_q.pop_front();
        if ({wb_addr, wb_data} !== exp_wb) begin
          bad++;
          $display("FAIL wb_data got addr=%0d data=%h exp addr=%0d data=%h",
                   wb_addr, wb_data, exp_wb[9:8], exp_wb[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic imm,
                                     input logic [1:0] rd, input logic [1:0] rs,
                                     input logic [7:0] lo);
    return {op, imm, rd, rs, lo};
  endfunction

  task automatic dbg_check(input logic [1:0] addr, input logic [7:0] expv, input string name);
    dbg_addr = addr;
    #1;
    total++;
    if (dbg_data !== expv) begin
      bad++;
      $display("FAIL %s got r%0d=%h exp %h", name, addr, dbg_data, expv);
    end
  endtask

  // Starts and ends on a negedge with the unit idle; keeps instr_valid high with an
  // illegal opcode while busy to show that non-IDLE offers are ignored.
  task automatic run_instr(input logic [15:0] ins, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [1:0] ewa, input logic [7:0] ewd, input string name);
    instr = ins;
    instr_valid = 1'b1;
    sb_q.push_back({ewa, ewd});
    @(negedge clk);
    total++;
    if ({instr_ready, alu_op, alu_a, alu_b} !== {1'b0, ins[15:13], ea, eb}) begin
      bad++;
      $display("FAIL %s_accept got rdy=%b op=%b a=%h b=%h exp rdy=0 op=%b a=%h b=%h",
               name, instr_ready, alu_op, alu_a, alu_b, ins[15:13], ea, eb);
    end
    instr = 16'hA000;
    @(negedge clk);
    total++;
    if ({instr_ready, wb_valid, err} !== 3'b000) begin
      bad++;
      $display("FAIL %s_exec got rdy=%b wbv=%b err=%b exp 000", name, instr_ready, wb_valid, err);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if ({instr_ready, wb_valid, err, alu_op, alu_a, alu_b} !== {3'b110, ins[15:13], ea, eb}) begin
      bad++;
      $display("FAIL %s_wb got rdy=%b wbv=%b err=%b op=%b a=%h b=%h exp rdy=1 wbv=1 err=0 op=%b a=%h b=%h",
               name, instr_ready, wb_valid, err, alu_op, alu_a, alu_b, ins[15:13], ea, eb);
    end
    @(negedge clk);
    total++;
    if ({instr_ready, wb_valid, wb_addr, wb_data} !== {2'b10, ewa, ewd}) begin
      bad++;
      $display("FAIL %s_after got rdy=%b wbv=%b addr=%0d data=%h exp rdy=1 wbv=0 addr=%0d data=%h",
               name, instr_ready, wb_valid, wb_addr, wb_data, ewa, ewd);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, err} !== {1'b1, 31'b0}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b op=%b a=%h b=%h wbv=%b addr=%0d data=%h err=%b exp 1/0",
               instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, err);
    end
    for (int i = 0; i < 4; i++) dbg_check(i[1:0], 8'h00, "reset_rf");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b exp 1", instr_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add_imm();
    run_instr(mk(3'b000, 1'b1, 2'd1, 2'd0, 8'h05), 8'h00, 8'h05, 2'd1, 8'h05, "add_imm");
    dbg_check(2'd1, 8'h05, "add_imm_r1");
  endtask

  task automatic test_reg_ops();
    run_instr(mk(3'b000, 1'b1, 2'd2, 2'd0, 8'h03), 8'h00, 8'h03, 2'd2, 8'h03, "add_r2");
    run_instr(mk(3'b001, 1'b0, 2'd3, 2'd1, 8'h02), 8'h05, 8'h03, 2'd3, 8'h02, "sub_reg");
    run_instr(mk(3'b110, 1'b0, 2'd3, 2'd2, 8'h01), 8'h03, 8'h05, 2'd3, 8'h01, "slt_reg");
    run_instr(mk(3'b111, 1'b0, 2'd3, 2'd0, 8'h00), 8'h00, 8'h00, 2'd3, 8'h01, "bz_reg");
    dbg_check(2'd2, 8'h03, "reg_ops_r2");
    dbg_check(2'd3, 8'h01, "reg_ops_r3");
  endtask

  task automatic test_r0_write();
    run_instr(mk(3'b000, 1'b1, 2'd0, 2'd0, 8'hFF), 8'h00, 8'hFF, 2'd0, 8'hFF, "r0_write");
    dbg_check(2'd0, 8'h00, "r0_stays_zero");
  endtask

  task automatic test_illegal();
    instr = mk(3'b101, 1'b1, 2'd2, 2'd1, 8'h33);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if ({err, instr_ready, wb_valid, alu_op, alu_a, alu_b} !== {3'b110, 3'b000, 8'h00, 8'hFF}) begin
      bad++;
      $display("FAIL illegal_pulse got err=%b rdy=%b wbv=%b op=%b a=%h b=%h exp err=1 rdy=1 wbv=0 op=000 a=00 b=ff",
               err, instr_ready, wb_valid, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    total++;
    if ({err, instr_ready, wb_valid} !== 3'b010) begin
      bad++;
      $display("FAIL illegal_after got err=%b rdy=%b wbv=%b exp err=0 rdy=1 wbv=0", err, instr_ready, wb_valid);
    end
    dbg_check(2'd2, 8'h03, "illegal_rf");
  endtask

  task automatic test_back_to_back();
    for (int j = 1; j <= 4; j++) sb_q.push_back({2'd1, 8'(j)});
    instr = mk(3'b000, 1'b1, 2'd1, 2'd1, 8'h01);
    instr_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 10) instr_valid = 1'b0;
      total++;
      if (instr_ready !== ((k % 3) == 0)) begin
        bad++;
        $display("FAIL b2b_ready cycle=%0d got %b exp %b", k, instr_ready, (k % 3) == 0);
      end
      if ((k % 3) == 1) begin
        total++;
        if ({alu_a, alu_b} !== {8'((k - 1) / 3), 8'h01}) begin
          bad++;
          $display("FAIL b2b_operands cycle=%0d got a=%h b=%h exp a=%h b=01", k, alu_a, alu_b, 8'((k - 1) / 3));
        end
      end
    end
    @(negedge clk);
    dbg_check(2'd1, 8'h04, "b2b_r1");
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drained got %0d pending exp 0", sb_q.size());
    end
  endtask

  task automatic test_reset_in_exec();
    instr = mk(3'b000, 1'b1, 2'd2, 2'd0, 8'h7F);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, err} !== {1'b1, 31'b0}) begin
      bad++;
      $display("FAIL rst_exec_outputs got rdy=%b op=%b a=%h b=%h wbv=%b addr=%0d data=%h err=%b exp 1/0",
               instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({instr_ready, wb_valid} !== 2'b10) begin
        bad++;
        $display("FAIL rst_exec_idle cycle=%0d got rdy=%b wbv=%b exp rdy=1 wbv=0", k, instr_ready, wb_valid);
      end
    end
    dbg_check(2'd2, 8'h00, "rst_exec_r2");
    run_instr(mk(3'b000, 1'b1, 2'd3, 2'd0, 8'h11), 8'h00, 8'h11, 2'd3, 8'h11, "post_reset");
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_reg_ops();
    test_r0_write();
    test_illegal();
    test_reset();
    test_back_to_back();
    test_reset_in_exec();
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL final_drained got %0d pending exp 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port instr_valid  input  1  instruction offered this cycle.
REQ-004 SHALL have port instr  input  16  instruction: [15:13] op, [12] imm flag, [11:10] rd, [9:8] rs, [7:0] imm8 (imm=1) or [1:0] rt (imm=0).
REQ-005 SHALL have port instr_ready  output  1  unit can accept; high only in state IDLE.
REQ-006 SHALL have port alu_op  output  3  registered operation code to the downstream ALU.
REQ-007 SHALL have port alu_a  output  8  registered operand A to the ALU.
REQ-008 SHALL have port alu_b  output  8  registered operand B to the ALU.
REQ-009 SHALL have port alu_ans  input  8  ALU result, registered inside the ALU one edge after operands are sampled.
REQ-010 SHALL have port wb_valid  output  1  one-cycle pulse on writeback.
REQ-011 SHALL have port wb_addr  output  2  destination register of the writeback.
REQ-012 SHALL have port wb_data  output  8  value written back.
REQ-013 SHALL have port err  output  1  one-cycle pulse on an illegal op.
REQ-014 SHALL have port dbg_addr  input  2  register-file debug read address.
REQ-015 SHALL have port dbg_data  output  8  combinational read of register dbg_addr.

Function
REQ-016 SHALL contain a 4x8-bit register file r0..r3; r0 reads as 0 and ignores writes.
REQ-017 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready = (state==IDLE).
REQ-018 SHALL accept an instruction on an edge where state==IDLE and instr_valid=1; instr ignored otherwise.
REQ-019 On accept of legal op (000,001,010,011,100,110,111) SHALL load alu_op=op, alu_a=r[rs], alu_b=imm8 if imm=1 else r[rt], latch rd, go EXEC.
REQ-020 Operand values SHALL be register contents as of the accept edge (prior writeback already committed).
REQ-021 alu_op/alu_a/alu_b SHALL hold stable from accept edge through end of WB.
REQ-022 In EXEC SHALL advance to WB at next edge (ALU captures result on that edge).
REQ-023 In WB, at next edge SHALL write alu_ans into r[rd] (dropped if rd=0), set wb_valid=1, wb_addr=rd, wb_data=alu_ans, go IDLE.
REQ-024 wb_valid SHALL be high exactly one cycle; wb_addr/wb_data hold last value afterward.
REQ-025 Latency SHALL be: accept edge T0, ALU sample T1, writeback edge T2, wb_valid high in cycle after T2; max throughput one instruction per 3 cycles.
REQ-026 rd=0 SHALL still pulse wb_valid with wb_addr=0, wb_data=alu_ans; r0 stays 0.
REQ-027 Op 101 SHALL be accepted, pulse err for one cycle, not change alu_* or the register file, and remain in IDLE.
REQ-028 instr_valid held high continuously SHALL result in a new accept every 3 cycles, each instr sampled only at its accept edge.
REQ-029 All arithmetic SHALL be done by the ALU; issue_unit performs no width extension and treats values as 8-bit unsigned.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, r0..r3=0, alu_op=000, alu_a=0, alu_b=0, wb_valid=0, wb_addr=0, wb_data=0, err=0.
REQ-031 Reset in EXEC or WB SHALL drop the in-flight instruction with no writeback and no wb_valid pulse.
REQ-032 After rst_n rises, instr_ready SHALL be 1 and first accept SHALL occur at first edge with instr_valid=1.

Verification
REQ-033 Reset, then ADD r1 = r0 + imm 0x05 -> alu_a=0x00, alu_b=0x05, wb_valid at T2+1 with wb_addr=1, wb_data=0x05; dbg_addr=1 reads 0x05.
REQ-034 r1=0x05; r2=r0+0x03; SUB r3=r1-r2 (reg mode) -> wb_data=0x02; then SLT r3=r2<r1 -> 0x01; BZ r3 on r0 -> 0x01.
REQ-035 ADD r0 = r0 + 0xFF -> wb_valid=1, wb_addr=0, wb_data=0xFF, dbg read r0 = 0x00.
REQ-036 Op 101 offered -> err pulses one cycle, no wb_valid, alu_* unchanged, instr_ready stays 1.
REQ-037 instr_valid held high with 4 back-to-back ADD imm 0x01 to r1 -> accepts exactly every 3 cycles, r1 ends 0x04 (each uses previous writeback).
REQ-038 Assert rst_n low during EXEC of ADD r2=r0+0x7F -> no wb_valid, r2=0x00, all outputs at reset values, instr_ready=1 after release.
